// File: rtl/rom_load_arbiter_pkg.sv
// rom_load_arbiter_pkg
// Shared definitions for the Galaxian program-ROM load arbiter: the arbiter
// state encoding and the default geometry / settle-period parameters.
package rom_load_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_WAIT, // no image loaded yet
    ST_LOAD, // HPS download in progress
    ST_HOLD, // settle period after a download
    ST_RUN   // core running, ROM port serves reads
  } arb_state_e;

  localparam int unsigned AW_DEFAULT          = 14;
  localparam int unsigned ROM_SIZE_DEFAULT    = 16384;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/rom_load_arbiter_if.sv
// rom_load_arbiter_if
// Bundles the HPS download port (ioctl_*), the core read port (cpu_*), the
// block-RAM port (rom_*) and the status outputs of rom_load_arbiter.
//   slave  : the arbiter's view (consumes ioctl/cpu/rom_dout, drives the rest)
//   master : the surroundings' view (hps_io, core and ROM together)
interface rom_load_arbiter_if
  import rom_load_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEFAULT
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ack;
  logic [7:0]    cpu_data;
  logic [AW-1:0] rom_addr;
  logic          rom_we;
  logic [7:0]    rom_din;
  logic [7:0]    rom_dout;
  logic          core_reset;
  logic          dn_error;
  logic [AW:0]   dn_bytes;

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  cpu_rd, cpu_addr, rom_dout,
    output cpu_ack, cpu_data, rom_addr, rom_we, rom_din,
    output core_reset, dn_error, dn_bytes
  );

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output cpu_rd, cpu_addr, rom_dout,
    input  cpu_ack, cpu_data, rom_addr, rom_we, rom_din,
    input  core_reset, dn_error, dn_bytes
  );
endinterface

// File: rtl/rom_load_arbiter_hold_timer.sv
// hold_timer
// Loadable down-counter with a zero flag, used to time the settle period
// between the end of a download and the release of the core reset.
//   clk, rst : clock and asynchronous active-high reset
//   load     : load load_val (has priority over dec)
//   dec      : decrement by one, stops at zero
//   zero     : count is zero
module hold_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);
endmodule

// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter
// Shares the single Galaxian program-ROM port between HPS download writes and
// core read fetches, and holds the core in reset until an image is loaded and
// for HOLD_CYCLES cycles after every download.
//   clk_sys : system clock, rising edge
//   RESET   : asynchronous active-high reset
//   bus     : ioctl download port, cpu read port, ROM port, status outputs
module rom_load_arbiter
  import rom_load_arbiter_pkg::*;
#(
  parameter int unsigned AW          = AW_DEFAULT,
  parameter int unsigned ROM_SIZE    = ROM_SIZE_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input logic                 clk_sys,
  input logic                 RESET,
  rom_load_arbiter_if.slave   bus
);
  localparam int unsigned   CW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [24:0]   ROM_LIMIT = 25'(ROM_SIZE);
  localparam logic [AW:0]   BYTES_MAX = {1'b1, {AW{1'b0}}};

  arb_state_e    state_q, state_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_din_q, wr_din_d;
  logic          rd_pend_q, rd_pend_d;
  logic [7:0]    cpu_data_q, cpu_data_d;
  logic          core_reset_q, core_reset_d;
  logic          dn_error_q, dn_error_d;
  logic [AW:0]   dn_bytes_q, dn_bytes_d;

  logic timer_load, timer_dec, timer_zero;
  logic in_load, in_run, cpu_ack_w;

  assign in_load = (state_q == ST_LOAD);
  assign in_run  = (state_q == ST_RUN);
  // A read issued in the last RUN cycle before a download is never acked.
  assign cpu_ack_w = rd_pend_q && in_run;

  hold_timer #(.W(CW)) u_hold_timer (
    .clk      (clk_sys),
    .rst      (RESET),
    .load     (timer_load),
    .load_val (HOLD_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_din_d   = wr_din_q;
    cpu_data_d = cpu_data_q;
    dn_error_d = dn_error_q;
    dn_bytes_d = dn_bytes_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    // Download wins over everything; a fresh entry into LOAD clears status.
    if (bus.ioctl_download) begin
      state_d = ST_LOAD;
      if (!in_load) begin
        dn_error_d = 1'b0;
        dn_bytes_d = '0;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          state_d    = ST_HOLD;
          timer_load = 1'b1;
        end
        ST_HOLD: begin
          if (timer_zero) state_d = ST_RUN;
          else            timer_dec = 1'b1;
        end
        default: ;
      endcase
    end

    // Qualified on the current state, so a strobe coinciding with the fall of
    // ioctl_download still lands in the first HOLD cycle.
    if (in_load && bus.ioctl_wr) begin
      if (bus.ioctl_addr < ROM_LIMIT) begin
        wr_pend_d = 1'b1;
        wr_addr_d = bus.ioctl_addr[AW-1:0];
        wr_din_d  = bus.ioctl_dout;
        if (dn_bytes_q != BYTES_MAX) dn_bytes_d = dn_bytes_q + (AW+1)'(1);
      end else begin
        dn_error_d = 1'b1;
      end
    end

    rd_pend_d = in_run && bus.cpu_rd;
    if (cpu_ack_w) cpu_data_d = bus.rom_dout;

    core_reset_d = (state_d != ST_RUN);
  end

  // NOTE: every flop here is a control or status register, so all of them are
  // reset; the ROM contents themselves live outside and are never reset.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_WAIT;
      wr_pend_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_din_q     <= '0;
      rd_pend_q    <= 1'b0;
      cpu_data_q   <= '0;
      core_reset_q <= 1'b1;
      dn_error_q   <= 1'b0;
      dn_bytes_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      wr_pend_q    <= wr_pend_d;
      wr_addr_q    <= wr_addr_d;
      wr_din_q     <= wr_din_d;
      rd_pend_q    <= rd_pend_d;
      cpu_data_q   <= cpu_data_d;
      core_reset_q <= core_reset_d;
      dn_error_q   <= dn_error_d;
      dn_bytes_q   <= dn_bytes_d;
    end
  end

  // ROM port mux: the core owns the address in RUN, downloads own it otherwise.
  assign bus.rom_addr   = in_run ? bus.cpu_addr : wr_addr_q;
  assign bus.rom_we     = wr_pend_q;
  assign bus.rom_din    = wr_din_q;
  assign bus.cpu_ack    = cpu_ack_w;
  assign bus.cpu_data   = cpu_ack_w ? bus.rom_dout : cpu_data_q;
  assign bus.core_reset = core_reset_q;
  assign bus.dn_error   = dn_error_q;
  assign bus.dn_bytes   = dn_bytes_q;
endmodule
